// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - RV32M divide/remainder sequencer driving a shared external ALU
//
// Multi-cycle restoring divider. The subtract in each of the 32 iterations
// is done by an external ALU; this block only sequences it.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        asynchronous active-low reset
//   Start      division request, sampled only in IDLE
//   Op         00 DIV, 01 DIVU, 10 REM, 11 REMU
//   Dividend   rs1 operand
//   Divisor    rs2 operand
//   Busy       high while the FSM is not in IDLE
//   Done       one-cycle pulse when Result is updated
//   Result     quotient or remainder, held until the next Done
//   AluA/AluB  shared ALU operands
//   AluCtrl    ALU op select (000 ADD, 001 SUB)
//   AluSlt     ALU result select, constant 00
//   AluResult  shared ALU result
//   AluFlags   {Z,C,V,N}; C set on SUB when A < B unsigned
module div_sequencer (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] Dividend,
  input  logic [31:0] Divisor,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Result,
  output logic [31:0] AluA,
  output logic [31:0] AluB,
  output logic [2:0]  AluCtrl,
  output logic [1:0]  AluSlt,
  input  logic [31:0] AluResult,
  input  logic [3:0]  AluFlags
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] dvd_q, dvd_d;       // original dividend
  logic [31:0] dvs_q, dvs_d;       // original divisor
  logic [31:0] mag_q, mag_d;       // divisor magnitude
  logic [31:0] r_q, r_d;           // partial remainder
  logic [31:0] q_q, q_d;           // quotient shift register, later the final value
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_q, neg_d;       // final result must be negated
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;

  logic [31:0] dvd_mag, dvs_mag;
  logic [31:0] shifted;
  logic        take;
  logic        unused_flags;

  // Only the carry flag matters for the restoring step.
  assign unused_flags = ^{AluFlags[3], AluFlags[1:0]};

  // Op[0] set means unsigned; Op[1] set means remainder.
  assign dvd_mag = (!op_q[0] && dvd_q[31]) ? (~dvd_q + 32'd1) : dvd_q;
  assign dvs_mag = (!op_q[0] && dvs_q[31]) ? (~dvs_q + 32'd1) : dvs_q;

  assign shifted = {r_q[30:0], q_q[31]};
  // R[31] set means the shifted value has a hidden 33rd bit, so it always
  // exceeds the divisor even when the 32-bit compare says otherwise.
  assign take    = r_q[31] || !AluFlags[2];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    mag_d    = mag_q;
    r_d      = r_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    result_d = result_q;
    AluA     = 32'd0;
    AluB     = 32'd0;
    AluCtrl  = ALU_ADD;

    case (state_q)
      S_IDLE: begin
        if (Start) begin
          op_d    = Op;
          dvd_d   = Dividend;
          dvs_d   = Divisor;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        if (dvs_q == 32'd0) begin
          q_d     = op_q[1] ? dvd_q : 32'hFFFF_FFFF;
          state_d = S_DONE;
        end else begin
          q_d     = dvd_mag;
          mag_d   = dvs_mag;
          r_d     = 32'd0;
          cnt_d   = 5'd0;
          neg_d   = !op_q[0] && (op_q[1] ? dvd_q[31] : (dvd_q[31] ^ dvs_q[31]));
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        AluA    = shifted;
        AluB    = mag_q;
        AluCtrl = ALU_SUB;
        r_d     = take ? AluResult : shifted;
        q_d     = {q_q[30:0], take};
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (op_q[1]) begin
          q_d = neg_q ? (~r_q + 32'd1) : r_q;
        end else begin
          q_d = neg_q ? (~q_q + 32'd1) : q_q;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d   = 1'b1;
        result_d = q_q;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      dvd_q    <= 32'd0;
      dvs_q    <= 32'd0;
      mag_q    <= 32'd0;
      r_q      <= 32'd0;
      q_q      <= 32'd0;
      cnt_q    <= 5'd0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      mag_q    <= mag_d;
      r_q      <= r_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign Busy   = (state_q != S_IDLE);
  assign Done   = done_q;
  assign Result = result_q;
  assign AluSlt = 2'b00;

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - directed self-checking bench for div_sequencer
`timescale 1ns/1ps
module tb_div_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'b00;
  logic [31:0] Dividend = 32'd0;
  logic [31:0] Divisor = 32'd0;
  logic        Busy, Done;
  logic [31:0] Result, AluA, AluB, AluResult;
  logic [2:0]  AluCtrl;
  logic [1:0]  AluSlt;
  logic [3:0]  AluFlags;

  int tests = 0;
  int fails = 0;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  div_sequencer dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Op(Op),
    .Dividend(Dividend), .Divisor(Divisor),
    .Busy(Busy), .Done(Done), .Result(Result),
    .AluA(AluA), .AluB(AluB), .AluCtrl(AluCtrl), .AluSlt(AluSlt),
    .AluResult(AluResult), .AluFlags(AluFlags)
  );

  always #5 CLK = ~CLK;

  // Shared ALU model: ADD/SUB with {Z,C,V,N} flags.
  always_comb begin
    logic [31:0] res;
    logic        c, v;
    if (AluCtrl == 3'b001) begin
      res = AluA - AluB;
      c   = (AluA < AluB);
      v   = (AluA[31] != AluB[31]) && (res[31] != AluA[31]);
    end else begin
      res = AluA + AluB;
      c   = ({1'b0, AluA} + {1'b0, AluB}) > 33'h0_FFFF_FFFF;
      v   = (AluA[31] == AluB[31]) && (res[31] != AluA[31]);
    end
    AluResult = res;
    AluFlags  = {(res == 32'd0), c, v, res[31]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    Op = op; Dividend = a; Divisor = b; Start = 1'b1;
    @(posedge CLK);
    #1 Start = 1'b0;
    check("busy_after_start", {31'd0, Busy}, 32'd1);
    check("done_low_after_start", {31'd0, Done}, 32'd0);
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_res);
    int  n;
    bit  got;
    n = 0; got = 0;
    while (!got && n < 100) begin
      @(posedge CLK);
      #1 n++;
      if (Done) got = 1;
    end
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_result"}, Result, exp_res);
  endtask

  initial begin
    int done_seen;

    // Reset state
    #2 RST = 1'b0;
    #1;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_result", Result, 32'd0);
    check("rst_alua", AluA, 32'd0);
    check("rst_alub", AluB, 32'd0);
    check("rst_aluctrl", {29'd0, AluCtrl}, 32'd0);
    check("rst_aluslt", {30'd0, AluSlt}, 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b1;

    // Main function
    start_op(DIVU, 32'd100, 32'd7);         wait_done("divu_100_7", 35, 32'd14);
    start_op(REMU, 32'd100, 32'd7);         wait_done("remu_100_7", 35, 32'd2);
    start_op(REM,  32'hFFFF_FFF9, 32'd2);   wait_done("rem_m7_2", 35, 32'hFFFF_FFFF);
    start_op(DIV,  32'hFFFF_FFF9, 32'd2);   wait_done("div_m7_2", 35, 32'hFFFF_FFFD);
    start_op(DIVU, 32'hFFFF_FFFF, 32'd1);   wait_done("divu_max_1", 35, 32'hFFFF_FFFF);
    start_op(DIV,  32'd7, 32'hFFFF_FFFE);   wait_done("div_7_m2", 35, 32'hFFFF_FFFD);
    start_op(REM,  32'd7, 32'hFFFF_FFFE);   wait_done("rem_7_m2", 35, 32'd1);
    start_op(DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE); wait_done("divu_big", 35, 32'd1);
    start_op(REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE); wait_done("remu_big", 35, 32'd1);

    // Divide by zero
    start_op(DIV,  32'd5, 32'd0);           wait_done("div_5_0", 2, 32'hFFFF_FFFF);
    start_op(REMU, 32'd5, 32'd0);           wait_done("remu_5_0", 2, 32'd5);
    start_op(REM,  32'hFFFF_FFF9, 32'd0);   wait_done("rem_m7_0", 2, 32'hFFFF_FFF9);

    // Signed overflow
    start_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("div_ovf", 35, 32'h8000_0000);
    start_op(REM, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("rem_ovf", 35, 32'd0);

    // Start during ITER is ignored; ALU driven with SUB and divisor magnitude
    start_op(DIVU, 32'd100, 32'd7);
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    check("iter_aluctrl", {29'd0, AluCtrl}, 32'd1);
    check("iter_alub", AluB, 32'd7);
    Op = DIV; Dividend = 32'd5; Divisor = 32'd0; Start = 1'b1;
    @(posedge CLK);
    #1 Start = 1'b0;
    wait_done("ignored_start", 24, 32'd14);

    // Back-to-back: Start in the Done cycle
    start_op(DIVU, 32'd9, 32'd3);           wait_done("b2b", 35, 32'd3);
    start_op(DIV,  32'd20, 32'd4);          wait_done("b2b2", 35, 32'd5);

    // Asynchronous reset mid-ITER
    start_op(DIVU, 32'd100, 32'd7);
    repeat (10) @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    check("abort_busy", {31'd0, Busy}, 32'd0);
    check("abort_result", Result, 32'd0);
    check("abort_aluctrl", {29'd0, AluCtrl}, 32'd0);
    check("abort_alub", AluB, 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RST = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge CLK);
      #1 if (Done) done_seen++;
    end
    check("abort_no_done", done_seen, 32'd0);
    start_op(DIVU, 32'd9, 32'd3);           wait_done("after_abort", 35, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port RST, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port Start, input, 1: request a division; sampled only in IDLE.
REQ-004 SHALL have port Op, input, 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M semantics).
REQ-005 SHALL have port Dividend, input, 32: operand rs1.
REQ-006 SHALL have port Divisor, input, 32: operand rs2.
REQ-007 SHALL have port Busy, output, 1: high in every non-IDLE state.
REQ-008 SHALL have port Done, output, 1: one-cycle pulse when Result becomes valid.
REQ-009 SHALL have port Result, output, 32: quotient or remainder, held until the next Done.
REQ-010 SHALL have port AluA, output, 32: operand A to the shared ALU.
REQ-011 SHALL have port AluB, output, 32: operand B to the shared ALU.
REQ-012 SHALL have port AluCtrl, output, 3: ALU op select (000 ADD, 001 SUB).
REQ-013 SHALL have port AluSlt, output, 2: ALU result select, driven constant 00.
REQ-014 SHALL have port AluResult, input, 32: ALU result.
REQ-015 SHALL have port AluFlags, input, 4: {Z,C,V,N}; C is set on SUB when A < B unsigned.

Function
REQ-016 SHALL implement states IDLE, PREP, ITER, FIX, DONE.
REQ-017 IDLE with Start=1 SHALL latch Op/Dividend/Divisor and move to PREP; Start outside IDLE SHALL be ignored.
REQ-018 PREP SHALL form unsigned magnitudes (signed ops: two's-complement absolute value; unsigned ops: operand as is), clear the partial remainder R, load Q with the dividend magnitude, clear a 5-bit counter, and record the result sign.
REQ-019 PREP with Divisor==0 SHALL go directly to DONE with Result = 0xFFFFFFFF for DIV/DIVU and Result = original Dividend for REM/REMU.
REQ-020 PREP with nonzero Divisor SHALL go to ITER.
REQ-021 In ITER the block SHALL drive AluA={R[30:0],Q[31]}, AluB=divisor magnitude, AluCtrl=SUB.
REQ-022 An ITER step SHALL subtract when R[31]==1 or AluFlags[2]==0.
REQ-023 An ITER step SHALL update R to AluResult when it subtracts, else to AluA.
REQ-024 An ITER step SHALL update Q to {Q[30:0],subtract}.
REQ-025 ITER SHALL run exactly 32 cycles; the counter wraps 31->0 and moves the FSM to FIX.
REQ-026 Outside ITER the block SHALL drive AluA=0, AluB=0, AluCtrl=ADD.
REQ-027 FIX SHALL produce the quotient Q, negated for DIV when operand signs differ; the remainder R, negated for REM when the dividend was negative; unsigned ops unmodified. FIX then moves to DONE.
REQ-028 Overflow case DIV 0x80000000/0xFFFFFFFF SHALL yield 0x80000000; REM of the same SHALL yield 0.
REQ-029 DONE SHALL assert Done for one cycle, update Result, and return to IDLE.
REQ-030 Latency: Start sampled at edge 0 -> Done high in the cycle after edge 35; divide-by-zero -> Done after edge 2.
REQ-031 A new Start SHALL be accepted in the first IDLE cycle after DONE (back-to-back).

Reset
REQ-032 RST low SHALL force IDLE immediately, regardless of clock.
REQ-033 RST low SHALL clear Busy, Done, Result, R, Q and the counter.
REQ-034 RST low SHALL set AluA=0, AluB=0, AluCtrl=000, AluSlt=00.
REQ-035 Reset mid-operation SHALL abort the operation with no Done pulse.

Verification
REQ-036 DIVU 100/7 -> Result 14, Done 35 cycles after Start; REMU same operands -> 2.
REQ-037 REM -7/2 -> 0xFFFFFFFF; DIV -7/2 -> 0xFFFFFFFD; DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
REQ-038 DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with Done 2 cycles after Start.
REQ-039 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0.
REQ-040 Start pulsed during ITER -> ignored, first result unchanged; back-to-back Start after Done -> accepted.
REQ-041 RST low at ITER cycle 10 -> IDLE immediately, no Done; a following DIVU 9/3 -> 3.
